// File: rtl/rv32i_io_pkg.sv
// Shared constants for the RV32I memory-mapped I/O responder: register offsets,
// STATUS bit positions, reset values and the byte-lane merge helper.
package rv32i_io_pkg;

  typedef enum logic [3:0] {
    OFF_IO_OUT   = 4'd0,
    OFF_IO_IN    = 4'd1,
    OFF_MTIME_LO = 4'd2,
    OFF_MTIME_HI = 4'd3,
    OFF_MTIMECMP = 4'd4,
    OFF_STATUS   = 4'd5,
    OFF_SCRATCH  = 4'd6
  } off_e;

  localparam int unsigned STATUS_MATCH = 0;
  localparam int unsigned STATUS_IE    = 1;

  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rv32i_io_responder_if.sv
// Data-memory-stage bus as seen by the I/O responder: word address, write
// strobe, byte enables, write data and registered read data.
interface rv32i_io_responder_if;
  logic [31:2] d_addr;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;

  modport master (output d_addr, d_we, d_be, d_wdata, input d_rdata);
  modport slave  (input d_addr, d_we, d_be, d_wdata, output d_rdata);
endinterface

// File: rtl/rv32i_sync2.sv
// Two-flop synchronizer for asynchronous inputs; output lags input by two edges.
module rv32i_sync2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/rv32i_io_responder.sv
// Memory-mapped I/O block: GPIO out/in, 64-bit mtime with coherent hi-word
// snapshot, timer compare with sticky MATCH and registered interrupt.
module rv32i_io_responder
  import rv32i_io_pkg::*;
#(
  parameter logic [31:2] BASE_WADDR = 30'h0000_4000
) (
  input  logic                       clk,
  input  logic                       reset,
  rv32i_io_responder_if.slave        bus,
  input  logic [31:0]                io_in,
  output logic [31:0]                io_out,
  output logic                       irq
);

  logic [31:0] r_io_out;
  logic [63:0] r_mtime;
  logic [31:0] r_hold;
  logic [31:0] r_cmp;
  logic        r_match;
  logic        r_ie;
  logic [31:0] r_scratch;
  logic [31:0] r_rdata;
  logic        r_irq;

  logic        w_sel;
  off_e        w_off;
  logic        w_wr;
  logic [31:0] w_io_in_sync;
  logic [31:0] w_status;
  logic [31:0] w_rd_val;
  logic        w_match_set;
  logic        w_match_clr;

  rv32i_sync2 #(.WIDTH(32)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (io_in),
    .o_q   (w_io_in_sync)
  );

  assign w_sel       = (bus.d_addr[31:6] == BASE_WADDR[31:6]);
  assign w_off       = off_e'(bus.d_addr[5:2]);
  assign w_wr        = w_sel && bus.d_we;
  assign w_match_set = (r_mtime[31:0] == r_cmp);
  assign w_match_clr = w_wr && (w_off == OFF_STATUS) && bus.d_be[0]
                       && bus.d_wdata[STATUS_MATCH];

  always_comb begin
    w_status               = '0;
    w_status[STATUS_MATCH] = r_match;
    w_status[STATUS_IE]    = r_ie;
  end

  // Read mux samples registers before this cycle's write lands.
  always_comb begin
    w_rd_val = '0;
    case (w_off)
      OFF_IO_OUT:   w_rd_val = r_io_out;
      OFF_IO_IN:    w_rd_val = w_io_in_sync;
      OFF_MTIME_LO: w_rd_val = r_mtime[31:0];
      OFF_MTIME_HI: w_rd_val = r_hold;
      OFF_MTIMECMP: w_rd_val = r_cmp;
      OFF_STATUS:   w_rd_val = w_status;
      OFF_SCRATCH:  w_rd_val = r_scratch;
      default:      w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_io_out  <= '0;
      r_mtime   <= '0;
      r_hold    <= '0;
      r_cmp     <= CMP_RST;
      r_match   <= 1'b0;
      r_ie      <= 1'b0;
      r_scratch <= '0;
      r_rdata   <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_mtime <= r_mtime + 64'd1;
      r_rdata <= w_sel ? w_rd_val : '0;
      r_irq   <= r_match & r_ie;
      // Set has priority over a same-cycle software clear.
      r_match <= w_match_set | (r_match & ~w_match_clr);

      if (w_sel && (w_off == OFF_MTIME_LO)) r_hold <= r_mtime[63:32];

      if (w_wr) begin
        case (w_off)
          OFF_IO_OUT:   r_io_out  <= be_merge(r_io_out, bus.d_wdata, bus.d_be);
          OFF_MTIMECMP: r_cmp     <= be_merge(r_cmp, bus.d_wdata, bus.d_be);
          OFF_SCRATCH:  r_scratch <= be_merge(r_scratch, bus.d_wdata, bus.d_be);
          OFF_STATUS:   if (bus.d_be[0]) r_ie <= bus.d_wdata[STATUS_IE];
          default:      ;
        endcase
      end
    end
  end

  assign bus.d_rdata = r_rdata;
  assign io_out      = r_io_out;
  assign irq         = r_irq;

endmodule

// File: tb/tb_rv32i_io_responder.sv
// Self-checking bench for rv32i_io_responder: register-access vector table plus
// hand-written timer, synchronizer and reset sequences.
module tb_rv32i_io_responder;

  localparam logic [31:2] BASE = 30'h0000_4000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] io_in;
  logic [31:0] io_out;
  logic        irq;

  rv32i_io_responder_if bus ();

  rv32i_io_responder #(.BASE_WADDR(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .io_in  (io_in),
    .io_out (io_out),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    string       name;
    bit          sel;
    logic [3:0]  off;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [31:0] exp_io;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, bus.d_rdata, e.exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [3:0] off, input bit we,
                       input logic [3:0] be, input logic [31:0] wd);
    bus.d_addr  = sel ? {BASE[31:6], off} : {BASE[31:6] ^ 26'h1, off};
    bus.d_we    = we;
    bus.d_be    = be;
    bus.d_wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 4'h0, 32'h0);
    step();
  endtask

  task automatic access(input string name, input bit sel, input logic [3:0] off,
                        input bit we, input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] exp);
    sb_t e;
    drive(sel, off, we, be, wd);
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    step();
  endtask

  task automatic wait_cycle(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 200) begin
      idle();
      guard++;
    end
    check("wait_cycle", cyc, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    vecs.push_back('{"io_full",     1'b1, 4'd0, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF});
    vecs.push_back('{"io_lane1",    1'b1, 4'd0, 1'b1, 4'h2, 32'h0000_1200, 32'hDEAD_BEEF, 32'hDEAD_12EF});
    vecs.push_back('{"io_be0",      1'b1, 4'd0, 1'b1, 4'h0, 32'h1234_5678, 32'hDEAD_12EF, 32'hDEAD_12EF});
    vecs.push_back('{"io_rd",       1'b1, 4'd0, 1'b0, 4'h0, 32'h0,         32'hDEAD_12EF, 32'hDEAD_12EF});
    vecs.push_back('{"scr_wr",      1'b1, 4'd6, 1'b1, 4'hF, 32'h1234_5678, 32'h0000_0000, 32'hDEAD_12EF});
    vecs.push_back('{"scr_nosel",   1'b0, 4'd6, 1'b0, 4'h0, 32'h0,         32'h0000_0000, 32'hDEAD_12EF});
    vecs.push_back('{"scr_rd",      1'b1, 4'd6, 1'b0, 4'h0, 32'h0,         32'h1234_5678, 32'hDEAD_12EF});
    vecs.push_back('{"scr_rw_same", 1'b1, 4'd6, 1'b1, 4'h9, 32'hAABB_CCDD, 32'h1234_5678, 32'hDEAD_12EF});
    vecs.push_back('{"scr_merged",  1'b1, 4'd6, 1'b0, 4'h0, 32'h0,         32'hAA34_56DD, 32'hDEAD_12EF});
    vecs.push_back('{"nosel_wr_io", 1'b0, 4'd0, 1'b1, 4'hF, 32'h0BAD_0BAD, 32'h0000_0000, 32'hDEAD_12EF});
    vecs.push_back('{"off9_wr",     1'b1, 4'd9, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 32'hDEAD_12EF});
    vecs.push_back('{"off9_rd",     1'b1, 4'd9, 1'b0, 4'h0, 32'h0,         32'h0000_0000, 32'hDEAD_12EF});
    vecs.push_back('{"cmp_rst_rd",  1'b1, 4'd4, 1'b0, 4'h0, 32'h0,         32'hFFFF_FFFF, 32'hDEAD_12EF});
    vecs.push_back('{"status_rd",   1'b1, 4'd5, 1'b0, 4'h0, 32'h0,         32'h0000_0000, 32'hDEAD_12EF});

    // Reset held with a concurrent IO_OUT write that must be discarded.
    io_in = 32'h0;
    reset = 1'b1;
    drive(1'b1, 4'd0, 1'b1, 4'hF, 32'hFFFF_FFFF);
    step();
    step();
    check("rst_io_out", io_out, 32'h0);
    check("rst_rdata", bus.d_rdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);

    // Release: the current cycle is cycle 0 with mtime == 0.
    reset = 1'b0;
    cyc = 0;
    access("mtime_lo_c0", 1'b1, 4'd2, 1'b0, 4'h0, 32'h0, 32'd0);
    wait_cycle(10);
    access("mtime_lo_c10", 1'b1, 4'd2, 1'b0, 4'h0, 32'h0, 32'd10);
    access("mtime_hi_snap", 1'b1, 4'd3, 1'b0, 4'h0, 32'h0, 32'd0);

    foreach (vecs[i]) begin
      access(vecs[i].name, vecs[i].sel, vecs[i].off, vecs[i].we, vecs[i].be,
             vecs[i].wd, vecs[i].exp_rd);
      check({vecs[i].name, "_io_out"}, io_out, vecs[i].exp_io);
    end

    // io_in becomes visible only to reads sampled two cycles after the change.
    io_in = 32'hA5A5_0000;
    access("io_in_lag0", 1'b1, 4'd1, 1'b0, 4'h0, 32'h0, 32'h0);
    access("io_in_lag1", 1'b1, 4'd1, 1'b0, 4'h0, 32'h0, 32'h0);
    access("io_in_lag2", 1'b1, 4'd1, 1'b0, 4'h0, 32'h0, 32'hA5A5_0000);

    // Reset during a write to IO_OUT.
    reset = 1'b1;
    drive(1'b1, 4'd0, 1'b1, 4'hF, 32'hFFFF_FFFF);
    step();
    check("rst_wr_io_out", io_out, 32'h0);
    check("rst_wr_rdata", bus.d_rdata, 32'h0);
    reset = 1'b0;
    cyc = 0;

    // Timer compare at 20 with interrupts enabled.
    access("cmp_wr20", 1'b1, 4'd4, 1'b1, 4'hF, 32'd20, 32'hFFFF_FFFF);
    access("ie_wr", 1'b1, 4'd5, 1'b1, 4'h1, 32'h2, 32'h0);
    wait_cycle(20);
    access("status_c20", 1'b1, 4'd5, 1'b0, 4'h0, 32'h0, 32'h2);
    check("irq_c21", {31'h0, irq}, 32'h0);
    access("status_c21", 1'b1, 4'd5, 1'b0, 4'h0, 32'h0, 32'h3);
    check("irq_c22", {31'h0, irq}, 32'h1);
    access("status_clr", 1'b1, 4'd5, 1'b1, 4'h1, 32'h3, 32'h3);
    check("irq_c23", {31'h0, irq}, 32'h1);
    idle();
    check("irq_c24", {31'h0, irq}, 32'h0);

    // Clear and set of MATCH in the same cycle: set wins.
    access("cmp_wr40", 1'b1, 4'd4, 1'b1, 4'hF, 32'd40, 32'd20);
    wait_cycle(40);
    access("clr_at_match", 1'b1, 4'd5, 1'b1, 4'h1, 32'h1, 32'h2);
    access("set_wins", 1'b1, 4'd5, 1'b0, 4'h0, 32'h0, 32'h1);
    check("irq_ie_off", {31'h0, irq}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
